proc_ctrl_fsm: RTL and testbench
================================

Name: proc_ctrl_fsm

Overview:
Multi-cycle control FSM that sequences the processor datapath: program counter, program memory, register file, ALU, write-back mux and data memory. It replaces the ad-hoc comparator/inverter control. It generates every enable and select from the fetched opcode (instr[31:27]) and the current PC, and it tracks halt, illegal-opcode and retired-instruction status.

Parameters:
WIDTH, 9, PC width; must match the up-counter and program-memory address width
PROG_END_ADDR, 8, PC value of the last instruction; retiring it halts the core
OP_LW, 5'd4, load-word opcode
OP_SW, 5'd5, store-word opcode
OP_HALT, 5'd31, halt opcode
MEM_WAIT, 1, data-memory read latency in cycles for LW (legal range 1..7)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  leaves IDLE, or restarts from HALT
pc  input  WIDTH  current program counter value
instr  input  32  registered program-memory output
pc_en  output  1  single-cycle increment enable for the up-counter
pc_clr  output  1  single-cycle synchronous clear for the up-counter
pmem_en  output  1  program-memory read enable
alu_op  output  2  ALU operation, equal to the latched opcode[1:0]
reg_wr_en  output  1  register-file write enable
wb_sel  output  1  write-back mux select: 0 = ALU, 1 = data memory
dmem_en  output  1  data-memory enable
dmem_wr_en  output  1  data-memory write enable
busy  output  1  high in any state other than IDLE or HALT
halted  output  1  high in HALT
illegal  output  1  sticky flag: illegal opcode decoded
instr_count  output  16  retired-instruction count, saturating

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Reset (synchronous, highest priority, any state):
  - state goes to IDLE.
  - opcode register, wait_cnt, illegal and instr_count all go to 0.
  - All outputs are 0 the following cycle.
  - Reset mid-instruction aborts it; no pending reg or dmem write is issued.
- IDLE: all enables 0. start=1 -> FETCH.
- FETCH (1 cycle): pmem_en=1. Next state DECODE (instr is valid in DECODE).
- DECODE (1 cycle): latch opcode <= instr[31:27], then branch:
  - opcode 0..3 -> EXEC.
  - OP_LW or OP_SW -> MEM; wait_cnt is loaded with MEM_WAIT-1.
  - OP_HALT -> HALT.
  - any other opcode -> HALT with illegal<=1.
- EXEC (1 cycle): alu_op valid; the ALU registers its result at the end of this cycle. Next state WB.
- MEM:
  - dmem_en=1 throughout.
  - SW: dmem_wr_en=1 for exactly 1 cycle; pc_en=1 in that cycle; the instruction retires there.
  - LW: dmem_wr_en=0; stay in MEM while wait_cnt != 0, decrementing each cycle; wait_cnt==0 -> WB.
- WB (1 cycle):
  - reg_wr_en=1 and pc_en=1; the instruction retires.
  - wb_sel = (opcode==OP_LW); wb_sel is 0 in every other state.
- Retire cycle (WB, or MEM for SW):
  - instr_count increments, saturating at 16'hFFFF.
  - If pc==PROG_END_ADDR, next state is HALT; otherwise FETCH.
  - The PC wraps in the counter at 2^WIDTH-1 -> 0; no special handling here.
- HALT:
  - halted=1, busy=0, all enables 0.
  - start=1: pc_clr=1 in that cycle, illegal and instr_count clear, next state FETCH.
- start is ignored while busy=1.
- alu_op is driven continuously from the opcode register (0 after reset). Downstream ignores it outside EXEC.
- Per-instruction latency (MEM_WAIT=1):
  - ALU op: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LW: 3+MEM_WAIT cycles.
  - SW: 3 cycles.
  - Throughput is one instruction per latency; there is no overlap between instructions.
- Outputs are combinational decodes of the state and opcode registers; the only registered state is state, opcode, wait_cnt, illegal and instr_count.

Test Plan:
- Reset, then start pulse, with instr=ADD(op 0) at pc 0. Required response:
  - FETCH in cycle 1; reg_wr_en=1 and pc_en=1 together in cycle 4, wb_sel=0.
  - instr_count=1; next state FETCH.
- LW (op 4) with MEM_WAIT=2. Required response:
  - dmem_en high for 2 cycles, dmem_wr_en never high.
  - WB in cycle 5 with wb_sel=1 and reg_wr_en=1.
- SW (op 5). Required response:
  - dmem_wr_en high for exactly 1 cycle (cycle 3), together with pc_en.
  - reg_wr_en never high; instr_count increments.
- HALT (op 31), then opcode 6 after restart. Required response:
  - op 31: halted=1, busy=0, no pc_en, instr_count unchanged.
  - start in HALT: pc_clr pulses 1 cycle, then FETCH.
  - op 6: illegal=1 and halted=1.
- Nine ALU ops at pc 0..8 with PROG_END_ADDR=8. Required response: HALT entered right after the 9th WB, instr_count=9.
- Reset asserted during EXEC. Required response: the next cycle shows state IDLE, all outputs 0, no reg_wr_en and instr_count=0.

Source files
------------

// File: rtl/proc_ctrl_fsm.sv
// Multi-cycle control FSM for the processor datapath: sequences fetch, decode,
// execute, data-memory access and write-back, and tracks halt/illegal/retire status.
module proc_ctrl_fsm #(
  parameter int unsigned      WIDTH         = 9,
  parameter logic [WIDTH-1:0] PROG_END_ADDR = WIDTH'(8),
  parameter logic [4:0]       OP_LW         = 5'd4,
  parameter logic [4:0]       OP_SW         = 5'd5,
  parameter logic [4:0]       OP_HALT       = 5'd31,
  parameter int unsigned      MEM_WAIT      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pc,
  input  logic [31:0]      instr,
  output logic             pc_en,
  output logic             pc_clr,
  output logic             pmem_en,
  output logic [1:0]       alu_op,
  output logic             reg_wr_en,
  output logic             wb_sel,
  output logic             dmem_en,
  output logic             dmem_wr_en,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [15:0]      instr_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT - 1);

  logic [2:0]  state_q, state_d;
  logic [4:0]  opcode_q, opcode_d;
  logic [2:0]  wait_cnt_q, wait_cnt_d;
  logic        illegal_q, illegal_d;
  logic [15:0] instr_count_q, instr_count_d;

  logic [4:0]  fetched_op;
  logic        is_sw;
  logic        retire;
  logic        instr_unused;

  assign fetched_op   = instr[31:27];
  assign instr_unused = ^instr[26:0];
  assign is_sw        = (opcode_q == OP_SW);
  // A store retires in its single MEM cycle; everything else retires in WB.
  assign retire       = (state_q == S_WB) || ((state_q == S_MEM) && is_sw);

  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    wait_cnt_d    = wait_cnt_q;
    illegal_d     = illegal_q;
    instr_count_d = instr_count_q;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        opcode_d = fetched_op;
        if (fetched_op[4:2] == 3'b000) begin
          state_d = S_EXEC;
        end else if ((fetched_op == OP_LW) || (fetched_op == OP_SW)) begin
          state_d    = S_MEM;
          wait_cnt_d = WAIT_INIT;
        end else if (fetched_op == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        state_d = S_WB;
      end
      S_MEM: begin
        if (!is_sw) begin
          if (wait_cnt_q != 3'd0) wait_cnt_d = wait_cnt_q - 3'd1;
          else                    state_d    = S_WB;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
      end
      S_HALT: begin
        if (start) begin
          state_d       = S_FETCH;
          illegal_d     = 1'b0;
          instr_count_d = 16'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (retire) begin
      if (instr_count_q != 16'hFFFF) instr_count_d = instr_count_q + 16'd1;
      state_d = (pc == PROG_END_ADDR) ? S_HALT : S_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      opcode_q      <= 5'd0;
      wait_cnt_q    <= 3'd0;
      illegal_q     <= 1'b0;
      instr_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      wait_cnt_q    <= wait_cnt_d;
      illegal_q     <= illegal_d;
      instr_count_q <= instr_count_d;
    end
  end

  always_comb begin
    pc_en       = retire;
    pc_clr      = (state_q == S_HALT) && start;
    pmem_en     = (state_q == S_FETCH);
    alu_op      = opcode_q[1:0];
    reg_wr_en   = (state_q == S_WB);
    wb_sel      = (state_q == S_WB) && (opcode_q == OP_LW);
    dmem_en     = (state_q == S_MEM);
    dmem_wr_en  = (state_q == S_MEM) && is_sw;
    busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    halted      = (state_q == S_HALT);
    illegal     = illegal_q;
    instr_count = instr_count_q;
  end

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Scoreboard bench for proc_ctrl_fsm: per-cycle expected output words are queued by
// the stimulus process and compared by an independent monitor on the falling edge.
module tb_proc_ctrl_fsm;

  logic        clk;
  logic        reset;
  logic        start;
  logic [8:0]  pc_r;
  logic [31:0] instr_q;
  logic        pc_en, pc_clr, pmem_en, reg_wr_en, wb_sel;
  logic        dmem_en, dmem_wr_en, busy, halted, illegal;
  logic [1:0]  alu_op;
  logic [15:0] instr_count;

  logic [31:0] prog [0:15];

  typedef struct {
    string       name;
    logic [27:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  proc_ctrl_fsm #(
    .WIDTH(9),
    .PROG_END_ADDR(9'd8),
    .OP_LW(5'd4),
    .OP_SW(5'd5),
    .OP_HALT(5'd31),
    .MEM_WAIT(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .pc(pc_r),
    .instr(instr_q),
    .pc_en(pc_en),
    .pc_clr(pc_clr),
    .pmem_en(pmem_en),
    .alu_op(alu_op),
    .reg_wr_en(reg_wr_en),
    .wb_sel(wb_sel),
    .dmem_en(dmem_en),
    .dmem_wr_en(dmem_wr_en),
    .busy(busy),
    .halted(halted),
    .illegal(illegal),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment: the PC up-counter and the registered program memory.
  always @(posedge clk) begin
    if (reset || pc_clr) pc_r <= 9'd0;
    else if (pc_en)      pc_r <= pc_r + 9'd1;
  end

  initial instr_q = 32'd0;
  always @(posedge clk) begin
    if (pmem_en) instr_q <= prog[pc_r[3:0]];
  end

  function automatic logic [31:0] mk(input logic [4:0] op);
    return {op, 27'h0123456};
  endfunction

  // {pc_en, pc_clr, pmem_en, alu_op, reg_wr_en, wb_sel, dmem_en, dmem_wr_en, busy, halted, illegal, count}
  function automatic logic [27:0] ov(input logic pe, input logic pcl, input logic pm,
                                     input logic [1:0] a, input logic rw, input logic wb,
                                     input logic de, input logic dw, input logic bz,
                                     input logic hl, input logic il, input logic [15:0] c);
    return {pe, pcl, pm, a, rw, wb, de, dw, bz, hl, il, c};
  endfunction

  function automatic logic [27:0] e_idle();
    return ov(0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 16'd0);
  endfunction
  function automatic logic [27:0] e_fetch(input logic [1:0] a, input logic il, input logic [15:0] c);
    return ov(0, 0, 1, a, 0, 0, 0, 0, 1, 0, il, c);
  endfunction
  function automatic logic [27:0] e_dec(input logic [1:0] a, input logic il, input logic [15:0] c);
    return ov(0, 0, 0, a, 0, 0, 0, 0, 1, 0, il, c);
  endfunction
  function automatic logic [27:0] e_exec(input logic [1:0] a, input logic [15:0] c);
    return ov(0, 0, 0, a, 0, 0, 0, 0, 1, 0, 0, c);
  endfunction
  function automatic logic [27:0] e_wb(input logic [1:0] a, input logic wb, input logic [15:0] c);
    return ov(1, 0, 0, a, 1, wb, 0, 0, 1, 0, 0, c);
  endfunction
  function automatic logic [27:0] e_mem(input logic [1:0] a, input logic wr, input logic [15:0] c);
    return ov(wr, 0, 0, a, 0, 0, 1, wr, 1, 0, 0, c);
  endfunction
  function automatic logic [27:0] e_halt(input logic [1:0] a, input logic il, input logic [15:0] c,
                                         input logic clr);
    return ov(0, clr, 0, a, 0, 0, 0, 0, 0, 1, il, c);
  endfunction

  // Drive start for the current cycle, queue what this cycle must show, advance one clock.
  task automatic step(input string nm, input logic st, input logic [27:0] v);
    exp_t e;
    start  = st;
    e.name = nm;
    e.v    = v;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares the DUT output word against the queued expectation every cycle.
  initial begin
    exp_t        e;
    logic [27:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {pc_en, pc_clr, pmem_en, alu_op, reg_wr_en, wb_sel, dmem_en, dmem_wr_en,
               busy, halted, illegal, instr_count};
        n_tests++;
        if (act !== e.v) begin
          n_fail++;
          $display("FAIL %s: got %h required %h", e.name, act, e.v);
        end else begin
          $display("[TB] %s ok: %h", e.name, act);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 16; i++) prog[i] = mk(5'd0);
    prog[1] = mk(5'd4);
    prog[2] = mk(5'd5);
    prog[3] = mk(5'd31);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    step("reset_idle", 0, e_idle());

    // ADD at pc 0; start held high while busy must be ignored
    step("add_start",  1, e_idle());
    step("add_fetch",  1, e_fetch(2'd0, 0, 16'd0));
    step("add_decode", 1, e_dec(2'd0, 0, 16'd0));
    step("add_exec",   1, e_exec(2'd0, 16'd0));
    step("add_wb",     0, e_wb(2'd0, 0, 16'd0));

    // LW at pc 1 with a two-cycle memory wait
    step("lw_fetch",  0, e_fetch(2'd0, 0, 16'd1));
    step("lw_decode", 0, e_dec(2'd0, 0, 16'd1));
    step("lw_mem0",   0, e_mem(2'd0, 0, 16'd1));
    step("lw_mem1",   0, e_mem(2'd0, 0, 16'd1));
    step("lw_wb",     0, e_wb(2'd0, 1, 16'd1));

    // SW at pc 2 retires in its single MEM cycle
    step("sw_fetch",  0, e_fetch(2'd0, 0, 16'd2));
    step("sw_decode", 0, e_dec(2'd0, 0, 16'd2));
    step("sw_mem",    0, e_mem(2'd1, 1, 16'd2));

    // HALT at pc 3
    step("halt_fetch",  0, e_fetch(2'd1, 0, 16'd3));
    step("halt_decode", 0, e_dec(2'd1, 0, 16'd3));
    step("halt_hold0",  0, e_halt(2'd3, 0, 16'd3, 0));
    step("halt_hold1",  0, e_halt(2'd3, 0, 16'd3, 0));
    prog[0] = mk(5'd6);
    step("halt_restart", 1, e_halt(2'd3, 0, 16'd3, 1));

    // Illegal opcode 6 at pc 0 after restart
    step("ill_fetch",  0, e_fetch(2'd3, 0, 16'd0));
    step("ill_decode", 0, e_dec(2'd3, 0, 16'd0));
    step("ill_halt",   0, e_halt(2'd2, 1, 16'd0, 0));
    step("ill_sticky", 0, e_halt(2'd2, 1, 16'd0, 0));
    for (int k = 0; k < 9; k++) prog[k] = mk(5'(k % 4));
    step("ill_restart", 1, e_halt(2'd2, 1, 16'd0, 1));

    // Nine ALU ops at pc 0..8; the last one (pc 8) halts the core
    for (int k = 0; k < 9; k++) begin
      logic [1:0]  a, prev;
      logic [15:0] c;
      a    = 2'(k % 4);
      prev = (k == 0) ? 2'd2 : 2'((k - 1) % 4);
      c    = 16'(k);
      step($sformatf("run%0d_fetch", k),  0, e_fetch(prev, 0, c));
      step($sformatf("run%0d_decode", k), 0, e_dec(prev, 0, c));
      step($sformatf("run%0d_exec", k),   0, e_exec(a, c));
      step($sformatf("run%0d_wb", k),     0, e_wb(a, 0, c));
    end
    step("end_halt",    0, e_halt(2'd0, 0, 16'd9, 0));
    step("end_restart", 1, e_halt(2'd0, 0, 16'd9, 1));

    // ADD at pc 0, then reset during the EXEC of op 1 at pc 1
    step("pre_fetch0",  0, e_fetch(2'd0, 0, 16'd0));
    step("pre_decode0", 0, e_dec(2'd0, 0, 16'd0));
    step("pre_exec0",   0, e_exec(2'd0, 16'd0));
    step("pre_wb0",     0, e_wb(2'd0, 0, 16'd0));
    step("pre_fetch1",  0, e_fetch(2'd0, 0, 16'd1));
    step("pre_decode1", 0, e_dec(2'd0, 0, 16'd1));
    reset = 1'b1;
    step("rst_exec",  0, e_exec(2'd1, 16'd1));
    reset = 1'b0;
    step("rst_idle0", 0, e_idle());
    step("rst_idle1", 0, e_idle());

    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
